// File: rtl/grapheme_job_arb_pkg.sv
// Types private to the grapheme job arbiter.
package grapheme_job_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } grapheme_job_arb_st_t;

endpackage

// File: rtl/grapheme_node_prot_pkg.sv
// Shared grapheme node-chain protocol definitions: command encoding and word widths.
package grapheme_node_prot_pkg;

    localparam int GNODE_PROT_DATA_W = 32;
    localparam int GNODE_PROT_CMD_W  = 2;
    localparam int DATA_W            = GNODE_PROT_DATA_W;

    typedef enum logic [GNODE_PROT_CMD_W-1:0] {
        CMD_IDLE  = 2'd0,
        CMD_SOP   = 2'd1,
        CMD_VALID = 2'd2,
        CMD_EOP   = 2'd3
    } gnode_prot_cmd_t;

endpackage

// File: rtl/grapheme_job_arb_if.sv
// Requester, chain-ingress and chain-tail signals of the job arbiter.
interface grapheme_job_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int BFFR_SIZE = 5
);
    import grapheme_node_prot_pkg::*;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [DATA_W-1:0]            req_job_bffr [NUM_REQ][BFFR_SIZE];
    gnode_prot_cmd_t              chain_cmd;
    logic [GNODE_PROT_DATA_W-1:0] chain_data;
    logic                         chain_ready;
    gnode_prot_cmd_t              ret_cmd;
    logic [GNODE_PROT_DATA_W-1:0] ret_data;
    logic                         ret_ready;

    // master is the arbiter; slave is the requesters plus node chain around it.
    modport master (
        input  req_valid, req_job_bffr, chain_ready, ret_cmd, ret_data,
        output req_ready, chain_cmd, chain_data, ret_ready
    );

    modport slave (
        output req_valid, req_job_bffr, chain_ready, ret_cmd, ret_data,
        input  req_ready, chain_cmd, chain_data, ret_ready
    );

endinterface

// File: rtl/grapheme_job_arb_rr_arb.sv
// Round-robin picker: first set bit of req at or above ptr, wrapping to bit 0.
module rr_arb_onehot #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    always_comb begin : pick
        int   j;
        logic found;
        // NOTE: every output gets a default before the search loop so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/grapheme_job_arb.sv
// Round-robin job injector for the grapheme node chain with outstanding-job throttle.
module grapheme_job_arb
    import grapheme_node_prot_pkg::*;
    import grapheme_job_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int BFFR_SIZE  = 5,
    parameter int MAX_OUTSTD = 8,
    localparam int OW        = $clog2(MAX_OUTSTD + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sched_en,
    grapheme_job_arb_if.master     bus,
    output logic [OW-1:0]          outstd_cnt,
    output logic                   busy,
    output logic                   err_underflow
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (BFFR_SIZE > 1) ? $clog2(BFFR_SIZE) : 1;

    if (BFFR_SIZE < 2) begin : g_bffr_size_chk
        $error("grapheme_job_arb: BFFR_SIZE must be at least 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_chk
        $error("grapheme_job_arb: NUM_REQ must be in 2..8");
    end

    grapheme_job_arb_st_t state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]     word_cntr_q;
    logic [OW-1:0]        outstd_q;
    logic                 err_q;
    logic                 ret_ready_q;
    logic [DATA_W-1:0]    job_reg [BFFR_SIZE];

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_fire;
    logic                 retire;
    logic                 last_word;
    logic                 unused_ret_data;

    assign eligible   = bus.req_valid & {NUM_REQ{sched_en && (outstd_q < OW'(MAX_OUTSTD))}};
    assign grant_fire = (state_q == IDLE) && (|eligible);
    assign retire     = ret_ready_q && (bus.ret_cmd == CMD_EOP);
    assign last_word  = (word_cntr_q == CNT_W'(BFFR_SIZE - 1));

    rr_arb_onehot #(.N(NUM_REQ), .IW(PTR_W)) u_rr_arb (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d        = state_q;
        bus.chain_cmd  = CMD_IDLE;
        bus.chain_data = '0;
        case (state_q)
            IDLE: if (grant_fire) state_d = SEND;
            SEND: begin
                bus.chain_data = job_reg[word_cntr_q];
                if (word_cntr_q == '0)  bus.chain_cmd = CMD_SOP;
                else if (last_word)     bus.chain_cmd = CMD_EOP;
                else                    bus.chain_cmd = CMD_VALID;
                if (bus.chain_ready && last_word) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            word_cntr_q <= '0;
            outstd_q    <= '0;
            err_q       <= 1'b0;
            ret_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_ready_q <= 1'b1;
            if (grant_fire) begin
                rr_ptr_q    <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                word_cntr_q <= '0;
            end else if (state_q == SEND && bus.chain_ready) begin
                word_cntr_q <= last_word ? '0 : word_cntr_q + CNT_W'(1);
            end
            // A grant and a retire in the same cycle cancel; a lone retire at zero is an error.
            case ({grant_fire, retire})
                2'b10: outstd_q <= outstd_q + OW'(1);
                2'b01: begin
                    if (outstd_q == '0) err_q <= 1'b1;
                    else                outstd_q <= outstd_q - OW'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: job buffer is pure datapath, always written before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            for (int w = 0; w < BFFR_SIZE; w++) begin
                job_reg[w] <= bus.req_job_bffr[grant_idx][w];
            end
        end
    end

    assign bus.req_ready   = grant_fire ? grant : '0;
    assign bus.ret_ready   = ret_ready_q;
    assign outstd_cnt      = outstd_q;
    assign busy            = (state_q != IDLE);
    assign err_underflow   = err_q;
    assign unused_ret_data = ^bus.ret_data;

endmodule

// File: doc/grapheme_job_arb.md
Name: grapheme_job_arb

Overview:
- Round-robin scheduler that shares the grapheme node chain ingress between NUM_REQ job sources (host/DMA/engines).
- Captures one complete job buffer from the granted requester. Serializes it as a SOP/VALID/EOP packet onto the first grapheme node's ingress port.
- Tracks in-flight jobs by watching retired packets on the chain tail. Throttles new injections at MAX_OUTSTD.

Parameters:
- NUM_REQ, 4, number of job requesters (2..8)
- BFFR_SIZE, 5, words per job packet; word 0 is the header carrying job_dst
- MAX_OUTSTD, 8, maximum jobs injected but not yet retired

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- sched_en  input  1  allow new grants; does not abort a packet in flight
- req_valid  input  NUM_REQ  requester i has a full job buffer ready
- req_job_bffr  input  [DATA_W-1:0] x [NUM_REQ][BFFR_SIZE]  job buffers, unpacked
- req_ready  output  NUM_REQ  one-hot; buffer i captured at this clock edge
- chain_cmd  output  gnode_prot_cmd_t  IDLE/SOP/VALID/EOP to the node chain
- chain_data  output  GNODE_PROT_DATA_W  packet word
- chain_ready  input  1  chain accepts the current word
- ret_cmd  input  gnode_prot_cmd_t  chain tail (retired packets)
- ret_data  input  GNODE_PROT_DATA_W  unused except for sim checks
- ret_ready  output  1  always 1 out of reset; retired packets are sinks
- outstd_cnt  output  $clog2(MAX_OUTSTD+1)  jobs in flight
- busy  output  1  FSM not in IDLE
- err_underflow  output  1  sticky; retire seen with outstd_cnt==0

Behaviour:
- Reset (rst_n low at posedge) sets:
  - FSM IDLE, rr_ptr=0, word_cntr=0, outstd_cnt=0, err_underflow=0
  - chain_cmd=IDLE, req_ready=0, busy=0, ret_ready=0
  - ret_ready is 1 from the first cycle after reset.
- Reset mid-packet drops the packet. No EOP is emitted. Downstream nodes rely on their own node_en/reset.
- FSM states: IDLE, SEND.
- IDLE behaviour:
  - eligible = req_valid & {NUM_REQ{sched_en && outstd_cnt<MAX_OUTSTD}}.
  - Grant g is the first eligible index searching from rr_ptr upward with wrap.
  - req_ready = onehot(g) combinationally while in IDLE and eligible is nonzero; otherwise req_ready=0.
  - On that edge: job_reg <= req_job_bffr[g], rr_ptr <= (g+1) mod NUM_REQ, outstd_cnt increments, state -> SEND, word_cntr=0.
- SEND behaviour:
  - chain_cmd is SOP when word_cntr==0, EOP when word_cntr==BFFR_SIZE-1, otherwise VALID.
  - chain_data = job_reg[word_cntr]. Both are stable while chain_ready=0.
  - word_cntr advances only on chain_ready.
  - EOP accepted -> IDLE, so chain_cmd=IDLE for at least one cycle between packets.
  - Latency: req_valid sampled in IDLE at cycle N; SOP driven at N+1. Minimum packet period is BFFR_SIZE+1 cycles.
  - BFFR_SIZE==1 is not supported (enforced by elaboration $error).
- Outstanding count:
  - +1 at grant; -1 when ret_cmd==EOP (ret_ready=1).
  - Simultaneous grant and retire: unchanged.
  - Retire at 0: count stays 0 and err_underflow is set.
  - Grant is blocked when outstd_cnt==MAX_OUTSTD, even if a retire occurs in the same cycle; it resumes the next cycle.
- sched_en low during SEND: the current packet completes, then no new grants.
- Fairness: any requester with valid held is granted within NUM_REQ grants.
- Header word is passed unmodified; requesters own job_dst.

Decomposition:
- grapheme_node_prot_pkg provides the existing items: gnode_prot_cmd_t, GNODE_PROT_DATA_W, GNODE_PROT_CMD_W, DATA_W.
- New grapheme_job_arb_pkg holds the FSM enum grapheme_job_arb_st_t {IDLE, SEND}.
- One sub-module, rr_arb_onehot, parameterized by N. Inputs req and ptr; output grant one-hot plus grant index.

Test Plan:
- Single job: req_valid[2]=1, buffer words 0x10..0x14, chain_ready=1.
  - Expect req_ready[2] for one cycle, then SOP 0x10, VALID 0x11..0x13, EOP 0x14 on consecutive cycles.
  - Expect outstd_cnt=1.
- Round-robin: all four req_valid held.
  - Expect grant order 0,1,2,3,0, with IDLE cycles between packets.
  - Expect no requester granted twice before all others.
- Backpressure: chain_ready=0 for 3 cycles at word 2.
  - Expect chain_cmd=VALID and chain_data=word2 held constant; the packet then completes with 5 accepted words.
- Throttle: no retires, continuous requests.
  - Expect exactly 8 grants, then outstd_cnt=8 and no req_ready.
  - One ret_cmd=EOP -> count 7 -> exactly one more grant.
- Simultaneous events, then underflow:
  - Grant and ret EOP in the same cycle -> outstd_cnt unchanged.
  - ret EOP at outstd_cnt=0 -> count 0, err_underflow=1 and sticky until reset.
- Control: sched_en dropped mid-packet -> packet finishes with EOP, then busy=0 with no further grants.
  - rst_n low mid-packet -> next cycle chain_cmd=IDLE and outstd_cnt=0.
